line_text_reader: RTL and testbench
===================================

LINE_TEXT_READER -- requirements
Module: line_text_reader

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 10, character-memory word address width.
REQ-002 Parameters (name, default, meaning): LINE_W, 8, line index width.
REQ-003 Ports (name, direction, width, meaning): clk, in, 1, sole clock, all state on rising edge.
REQ-004 Ports: rst, in, 1, synchronous active-high reset.
REQ-005 Ports: start, in, 1, one-cycle request to stream line line_sel; sampled only in IDLE.
REQ-006 Ports: line_sel, in, LINE_W, line index captured with start.
REQ-007 Ports: map_line, out, LINE_W, line index driven to the line mapper.
REQ-008 Ports: map_range, in, 2*ADDR_W, mapper result valid 1 cycle after map_line is driven; [2*ADDR_W-1:ADDR_W] = last word address inclusive, [ADDR_W-1:0] = first word address.
REQ-009 Ports: mem_addr, out, ADDR_W, word address to character memory.
REQ-010 Ports: mem_dout, in, 16, character word valid 1 cycle after mem_addr is driven; [15:8] first char, [7:0] second char.
REQ-011 Ports: char_data, out, 8, ASCII output byte.
REQ-012 Ports: char_valid, out, 1, char_data valid.
REQ-013 Ports: char_ready, in, 1, downstream accept; transfer when char_valid and char_ready are both high.
REQ-014 Ports: char_last, out, 1, marks final byte of the line; qualified by char_valid.
REQ-015 Ports: busy, out, 1, high in every state except IDLE.
REQ-016 Ports: done, out, 1, one-cycle pulse after the last transfer, or after an empty-line decision.

Function
REQ-017 States SHALL be IDLE, MAP_WAIT, MAP_CAP, FETCH_WAIT, FETCH_CAP, EMIT_HI, EMIT_LO, EMIT_NL, DONE.
REQ-018 IDLE + start: latch line_sel to map_line and go to MAP_WAIT; start in any other state is ignored.
REQ-019 MAP_WAIT -> MAP_CAP after 1 cycle; MAP_CAP captures first/last into registers and sets word pointer ptr = first.
REQ-020 MAP_CAP: if last < first (unsigned), the line is empty: go to DONE, emit no bytes.
REQ-021 Otherwise drive mem_addr = ptr -> FETCH_WAIT (1 cycle) -> FETCH_CAP captures mem_dout into a 16-bit word register -> EMIT_HI.
REQ-022 EMIT_HI presents word[15:8]; on transfer -> EMIT_LO. EMIT_LO presents word[7:0].
REQ-023 On EMIT_LO transfer: if ptr == last, go to EMIT_NL (macro on) or DONE (macro off); otherwise ptr <= ptr + 1 and re-enter fetch.
REQ-024 char_data and char_last SHALL hold stable while char_valid is high and char_ready is low; char_valid never drops without a transfer except on reset.
REQ-025 ptr SHALL be ADDR_W bits; last = 2^ADDR_W-1 terminates without wrap; no increment beyond last.
REQ-026 Bytes SHALL be emitted unmodified, including 0x20 padding; no character filtering.
REQ-027 DONE pulses done for 1 cycle, then returns to IDLE; start is accepted again the following cycle.
REQ-028 Throughput: one word costs 2 fetch cycles + 2 transfers; no prefetch required.

Reset
REQ-029 rst SHALL force IDLE: char_valid=0, char_last=0, done=0, busy=0, char_data=0, map_line=0, mem_addr=0, ptr/first/last/word=0.
REQ-030 rst asserted mid-line SHALL abort immediately; no done pulse; no further bytes; the same-cycle start is ignored.

Configuration
REQ-031 Macro LINE_NEWLINE_EN defined: after the last word, EMIT_NL presents 0x0A with char_last=1, then DONE; empty lines emit only 0x0A with char_last=1.
REQ-032 Macro LINE_NEWLINE_EN undefined: EMIT_NL unreachable; char_last=1 on the final EMIT_LO byte; empty lines emit nothing.

Verification
REQ-033 Line 0 (map first=0, last=3; words 0x3131, 0x3132, 0x7320, 0x2020), char_ready=1 -> bytes 31 31 31 32 73 20 20 20; char_last on the 8th byte (macro off); done 1 cycle after.
REQ-034 Line 1 (first=5, last=5; word 0x3174), char_ready toggling 1/0 -> bytes 31 74 with stable data during stalls; macro on -> 0A appended with char_last.
REQ-035 map_range first=9, last=4 -> zero bytes (macro off) or single 0A (macro on); done asserted.
REQ-036 rst asserted after 3rd transfer of line 0 -> char_valid=0 next cycle, busy=0, no done; fresh start of line 1 streams correctly.
REQ-037 start pulsed while busy with line_sel=1 during line 0 -> line 0 output unaffected, line 1 not streamed.
REQ-038 first=1022, last=1023 -> exactly 4 bytes from addresses 1022 and 1023; mem_addr never wraps to 0.

Source files
------------

// File: rtl/line_text_reader.sv
// line_text_reader
//   Streams one text line out of a 16-bit-per-word character memory as a
//   byte stream with a valid/ready handshake. A line index is translated
//   into an inclusive word-address range by an external line mapper
//   (1-cycle latency), then each word is fetched (1-cycle latency) and
//   emitted high byte first, low byte second. Bytes are passed through
//   unmodified.
//
// Optional feature (compile-time macro):
//   LINE_NEWLINE_EN  defined   -> a trailing 0x0A byte carrying char_last is
//                                 appended to every line (also to empty ones).
//                    undefined -> char_last rides on the final data byte and
//                                 empty lines produce no bytes at all.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle request, only honoured while idle
//   line_sel    line index captured with start
//   map_line    line index presented to the line mapper
//   map_range   mapper result {last, first}, valid one cycle after map_line
//   mem_addr    character memory word address
//   mem_dout    character word, valid one cycle after mem_addr
//   char_data   output byte
//   char_valid  output byte valid
//   char_ready  downstream accept
//   char_last   final byte of the line (qualified by char_valid)
//   busy        high whenever not idle
//   done        one-cycle pulse when the line is finished

module line_text_reader #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LINE_W-1:0]     line_sel,
    output logic [LINE_W-1:0]     map_line,
    input  logic [2*ADDR_W-1:0]   map_range,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [15:0]           mem_dout,
    output logic [7:0]            char_data,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  char_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_MAP_WAIT   = 4'd1;
    localparam logic [3:0] S_MAP_CAP    = 4'd2;
    localparam logic [3:0] S_FETCH_WAIT = 4'd3;
    localparam logic [3:0] S_FETCH_CAP  = 4'd4;
    localparam logic [3:0] S_EMIT_HI    = 4'd5;
    localparam logic [3:0] S_EMIT_LO    = 4'd6;
    localparam logic [3:0] S_EMIT_NL    = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

`ifdef LINE_NEWLINE_EN
    localparam logic [3:0] S_LINE_END = S_EMIT_NL;
`else
    localparam logic [3:0] S_LINE_END = S_DONE;
`endif

    logic [3:0]        state;
    // ptr is loaded with the first word address, so it doubles as the
    // captured "first" value; only "last" needs its own register.
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_addr;
    logic [15:0]       word;

    logic [ADDR_W-1:0] range_first;
    logic [ADDR_W-1:0] range_last;
    logic              xfer;

    assign range_first = map_range[ADDR_W-1:0];
    assign range_last  = map_range[2*ADDR_W-1:ADDR_W];
    assign xfer        = char_valid && char_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            map_line  <= '0;
            ptr       <= '0;
            last_addr <= '0;
            word      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        map_line <= line_sel;
                        state    <= S_MAP_WAIT;
                    end
                end
                S_MAP_WAIT: state <= S_MAP_CAP;
                S_MAP_CAP: begin
                    ptr       <= range_first;
                    last_addr <= range_last;
                    if (range_last < range_first)
                        state <= S_LINE_END;
                    else
                        state <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: state <= S_FETCH_CAP;
                S_FETCH_CAP: begin
                    word  <= mem_dout;
                    state <= S_EMIT_HI;
                end
                S_EMIT_HI: begin
                    if (xfer) state <= S_EMIT_LO;
                end
                S_EMIT_LO: begin
                    if (xfer) begin
                        // Stop on ptr == last before incrementing so that a
                        // range ending at the top address never wraps.
                        if (ptr == last_addr) begin
                            state <= S_LINE_END;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_FETCH_WAIT;
                        end
                    end
                end
                S_EMIT_NL: begin
                    if (xfer) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output byte is decoded from state and the held word register, so it
    // cannot change while a byte is stalled waiting for char_ready.
    always_comb begin
        char_valid = 1'b0;
        char_data  = 8'h00;
        char_last  = 1'b0;
        case (state)
            S_EMIT_HI: begin
                char_valid = 1'b1;
                char_data  = word[15:8];
            end
            S_EMIT_LO: begin
                char_valid = 1'b1;
                char_data  = word[7:0];
`ifndef LINE_NEWLINE_EN
                char_last  = (ptr == last_addr);
`endif
            end
            S_EMIT_NL: begin
                char_valid = 1'b1;
                char_data  = 8'h0A;
                char_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr = ptr;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_line_text_reader.sv
// Scoreboard bench for line_text_reader: a mapper table and character memory
// are modelled in the bench, each started line pushes its expected byte
// sequence into a queue, and a monitor pops and compares on every transfer.
module tb_line_text_reader;

    localparam int ADDR_W = 10;
    localparam int LINE_W = 8;

`ifdef LINE_NEWLINE_EN
    localparam bit NL_EN = 1'b1;
`else
    localparam bit NL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [LINE_W-1:0]   line_sel = '0;
    logic [LINE_W-1:0]   map_line;
    logic [2*ADDR_W-1:0] map_range = '0;
    logic [ADDR_W-1:0]   mem_addr;
    logic [15:0]         mem_dout = '0;
    logic [7:0]          char_data;
    logic                char_valid;
    logic                char_ready = 1'b1;
    logic                char_last;
    logic                busy;
    logic                done;

    logic [15:0]       mem       [1024];
    logic [ADDR_W-1:0] map_first [256];
    logic [ADDR_W-1:0] map_last  [256];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfer_count = 0;
    int   ready_mode = 0;
    bit   done_expected = 1'b0;
    bit   watch_hi = 1'b0;
    bit   stall_pend = 1'b0;
    exp_t held;

    line_text_reader #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .line_sel(line_sel),
        .map_line(map_line), .map_range(map_range),
        .mem_addr(mem_addr), .mem_dout(mem_dout),
        .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .char_last(char_last),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    // Synchronous mapper and character memory, one cycle latency each.
    always @(posedge clk) begin
        map_range <= {map_last[map_line], map_first[map_line]};
        mem_dout  <= mem[mem_addr];
    end

    // Downstream ready pattern: 0 = always, 1 = toggling, 2 = random.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       char_ready = 1'b1;
            1:       char_ready = ~char_ready;
            default: char_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a line is the high/low bytes of every word from first to
    // last inclusive (none if last < first), optionally followed by 0x0A.
    task automatic push_expected(input int line);
        int f;
        int l;
        exp_t e;
        f = int'(map_first[line]);
        l = int'(map_last[line]);
        for (int a = f; a <= l; a++) begin
            e.d = mem[a][15:8]; e.l = 1'b0;
            exp_q.push_back(e);
            e.d = mem[a][7:0];  e.l = (a == l) && !NL_EN;
            exp_q.push_back(e);
        end
        if (NL_EN) begin
            e.d = 8'h0A; e.l = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares every transfer, stall stability and done pulses.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid", char_valid, 1);
                chk("stall_data", char_data, held.d);
                chk("stall_last", char_last, held.l);
            end
            if (char_valid && char_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", char_data, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("char_data", char_data, e.d);
                    chk("char_last", char_last, e.l);
                end
                xfer_count++;
            end
            if (char_valid && watch_hi)
                chk("mem_addr_no_wrap", mem_addr >= 10'd1022, 1);
            stall_pend = char_valid && !char_ready;
            held.d = char_data;
            held.l = char_last;
            if (done) begin
                chk("done_expected", done_expected, 1);
                chk("done_queue_empty", exp_q.size(), 0);
                done_expected = 1'b0;
            end
        end
    end

    task automatic pulse_start(input int line);
        @(negedge clk);
        start = 1'b1;
        line_sel = LINE_W'(line);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && done_expected; i++) @(negedge clk);
        #1;
        chk({name, "_done_seen"}, done_expected, 0);
        if (done_expected) begin
            exp_q.delete();
            done_expected = 1'b0;
        end
        @(negedge clk);
        #1;
        chk({name, "_done_one_cycle"}, done, 0);
        chk({name, "_idle_after"}, busy, 0);
    endtask

    task automatic run_line(input string name, input int line, input int mode);
        ready_mode = mode;
        push_expected(line);
        done_expected = 1'b1;
        pulse_start(line);
        wait_done(name);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) begin
            map_first[i] = '0;
            map_last[i]  = '0;
        end
        mem[0] = 16'h3131; mem[1] = 16'h3132; mem[2] = 16'h7320; mem[3] = 16'h2020;
        mem[5] = 16'h3174;
        map_first[0] = 10'd0;    map_last[0] = 10'd3;
        map_first[1] = 10'd5;    map_last[1] = 10'd5;
        map_first[2] = 10'd9;    map_last[2] = 10'd4;
        map_first[3] = 10'd1022; map_last[3] = 10'd1023;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char_last", char_last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_char_data", char_data, 0);
        chk("rst_map_line", map_line, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        run_line("line0", 0, 0);
        run_line("line1", 1, 1);
        run_line("empty", 2, 0);
        watch_hi = 1'b1;
        run_line("top_addr", 3, 2);
        watch_hi = 1'b0;

        // Reset after the third transfer of line 0, with a same-cycle start.
        ready_mode = 0;
        push_expected(0);
        done_expected = 1'b1;
        xfer_count = 0;
        pulse_start(0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (xfer_count >= 3) break;
        end
        chk("abort_reached_3", xfer_count >= 3, 1);
        rst = 1'b1;
        start = 1'b1;
        line_sel = 8'd1;
        @(negedge clk);
        #1;
        chk("abort_valid", char_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        start = 1'b0;
        exp_q.delete();
        done_expected = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_stays_idle", busy, 0);
        run_line("after_abort", 1, 2);

        // start while busy must be ignored
        ready_mode = 0;
        push_expected(0);
        done_expected = 1'b1;
        pulse_start(0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        line_sel = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (8) @(negedge clk);
        chk("busy_start_idle", busy, 0);

        // Randomized lines
        for (int i = 0; i < 10; i++) begin
            int f;
            int l;
            f = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) == 0 && f > 0)
                l = $urandom_range(0, f - 1);
            else begin
                l = f + $urandom_range(0, 5);
                if (l > 1023) l = 1023;
            end
            map_first[4 + i] = ADDR_W'(f);
            map_last[4 + i]  = ADDR_W'(l);
            run_line("random", 4 + i, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
